// File: rtl/tt_pipe_alu_if.sv
// Handshake/bus bundle for tt_pipe_alu: operand input side and result output side.
interface tt_pipe_alu_if #(
   parameter int unsigned WIDTH   = 8,
   parameter int unsigned COUNT_W = 8
);
   logic               in_valid;
   logic               in_ready;
   logic [WIDTH-1:0]   in_a;
   logic [WIDTH-1:0]   in_b;
   logic [1:0]         in_mode;
   logic               acc_clr;
   logic               out_valid;
   logic               out_ready;
   logic [WIDTH-1:0]   out_data;
   logic               out_flag;
   logic [COUNT_W-1:0] out_count;

   // Producer/consumer side driving operands and accepting results.
   modport master (
      output in_valid, in_a, in_b, in_mode, acc_clr, out_ready,
      input  in_ready, out_valid, out_data, out_flag, out_count
   );

   // The arithmetic unit itself.
   modport slave (
      input  in_valid, in_a, in_b, in_mode, acc_clr, out_ready,
      output in_ready, out_valid, out_data, out_flag, out_count
   );
endinterface

// File: rtl/tt_pipe_alu.sv
// Two-stage pipelined ALU: stage 1 captures operands, stage 2 computes and
// holds the result. Valid/ready on both sides, persistent accumulator and a
// wrapping count of completed output transfers.
module tt_pipe_alu #(
   parameter int unsigned WIDTH   = 8,
   parameter int unsigned COUNT_W = 8
) (
   input  logic          clk,
   input  logic          rst,
   tt_pipe_alu_if.slave  bus
);

   typedef enum logic [1:0] {
      MODE_ADD    = 2'b00,
      MODE_SUB    = 2'b01,
      MODE_SATADD = 2'b10,
      MODE_ACC    = 2'b11
   } mode_e;

   logic               r_s1_valid;
   logic [WIDTH-1:0]   r_s1_a;
   logic [WIDTH-1:0]   r_s1_b;
   mode_e              r_s1_mode;

   logic               r_s2_valid;
   logic [WIDTH-1:0]   r_out_data;
   logic               r_out_flag;
   logic [WIDTH-1:0]   r_acc;
   logic [COUNT_W-1:0] r_count;

   logic               w_s2_adv;
   logic               w_s1_adv;
   logic               w_s2_load;
   logic               w_out_xfer;
   logic [WIDTH-1:0]   w_acc_base;
   logic [WIDTH:0]     w_add;
   logic [WIDTH:0]     w_sub;
   logic [WIDTH:0]     w_acc_sum;
   logic [WIDTH-1:0]   w_res_data;
   logic               w_res_flag;

   // Stall chain: a stage advances when it is empty or its successor advances.
   assign w_s2_adv   = !r_s2_valid || bus.out_ready;
   assign w_s1_adv   = !r_s1_valid || w_s2_adv;
   assign w_s2_load  = w_s2_adv && r_s1_valid;
   assign w_out_xfer = r_s2_valid && bus.out_ready;

   assign bus.in_ready  = w_s1_adv && !rst;
   assign bus.out_valid = r_s2_valid;
   assign bus.out_data  = r_out_data;
   assign bus.out_flag  = r_out_flag;
   assign bus.out_count = r_count;

   // Stage-2 arithmetic on WIDTH+1 bits; a clear on the loading edge zeroes the accumulator operand.
   always_comb begin
      w_acc_base = bus.acc_clr ? '0 : r_acc;
      w_add      = {1'b0, r_s1_a} + {1'b0, r_s1_b};
      w_sub      = {1'b0, r_s1_a} - {1'b0, r_s1_b};
      w_acc_sum  = {1'b0, w_acc_base} + {1'b0, r_s1_a};
      w_res_data = w_add[WIDTH-1:0];
      w_res_flag = w_add[WIDTH];
      unique case (r_s1_mode)
         MODE_ADD: begin
            w_res_data = w_add[WIDTH-1:0];
            w_res_flag = w_add[WIDTH];
         end
         MODE_SUB: begin
            w_res_data = w_sub[WIDTH-1:0];
            w_res_flag = w_sub[WIDTH];
         end
         MODE_SATADD: begin
            w_res_flag = w_add[WIDTH];
            w_res_data = w_add[WIDTH] ? '1 : w_add[WIDTH-1:0];
         end
         MODE_ACC: begin
            w_res_data = w_acc_sum[WIDTH-1:0];
            w_res_flag = w_acc_sum[WIDTH];
         end
         default: ;
      endcase
   end

   // Stage 1: capture operands whenever the stage can advance; holds while stalled.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_s1_valid <= 1'b0;
         r_s1_a     <= '0;
         r_s1_b     <= '0;
         r_s1_mode  <= MODE_ADD;
      end else if (w_s1_adv) begin
         r_s1_valid <= bus.in_valid;
         if (bus.in_valid) begin
            r_s1_a    <= bus.in_a;
            r_s1_b    <= bus.in_b;
            r_s1_mode <= mode_e'(bus.in_mode);
         end
      end
   end

   // Stage 2: register result and flag; data only changes when a real op loads.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_s2_valid <= 1'b0;
         r_out_data <= '0;
         r_out_flag <= 1'b0;
      end else if (w_s2_adv) begin
         r_s2_valid <= r_s1_valid;
         if (r_s1_valid) begin
            r_out_data <= w_res_data;
            r_out_flag <= w_res_flag;
         end
      end
   end

   // Accumulator: an ACC op loading stage 2 takes priority (its sum already includes any clear).
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_acc <= '0;
      end else if (w_s2_load && (r_s1_mode == MODE_ACC)) begin
         r_acc <= w_res_data;
      end else if (bus.acc_clr) begin
         r_acc <= '0;
      end
   end

   // Completed output transfer counter, wraps naturally.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_count <= '0;
      end else if (w_out_xfer) begin
         r_count <= r_count + COUNT_W'(1);
      end
   end

endmodule

// File: tb/tb_tt_pipe_alu.sv
// Scoreboard bench for tt_pipe_alu: expected {flag,data} pushed on accept,
// compared in order when results are presented on the output.
module tb_tt_pipe_alu;
   localparam int unsigned W  = 8;
   localparam int unsigned CW = 8;

   localparam logic [1:0] M_ADD = 2'b00;
   localparam logic [1:0] M_SUB = 2'b01;
   localparam logic [1:0] M_SAT = 2'b10;
   localparam logic [1:0] M_ACC = 2'b11;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   tt_pipe_alu_if #(.WIDTH(W), .COUNT_W(CW)) bus ();

   tt_pipe_alu #(.WIDTH(W), .COUNT_W(CW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int          n_checks = 0;
   int          n_errors = 0;
   logic [W:0]  sb_q[$];
   logic [W-1:0] m_acc   = '0;
   logic [CW-1:0] m_count = '0;
   logic [CW-1:0] cnt0;
   bit          tog_en;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Reference model returning {flag,data}; tracks the accumulator in op order.
   function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                        input logic [1:0] mode, input bit clr);
      int unsigned s;
      int unsigned full;
      full = 1 << W;
      if (clr) m_acc = '0;
      case (mode)
         M_ADD: begin
            s = int'(a) + int'(b);
            return {s >= full, W'(s % full)};
         end
         M_SUB: begin
            s = (int'(a) + full - int'(b)) % full;
            return {a < b, W'(s)};
         end
         M_SAT: begin
            s = int'(a) + int'(b);
            if (s >= full) return {1'b1, W'(full - 1)};
            return {1'b0, W'(s)};
         end
         default: begin
            s = int'(m_acc) + int'(a);
            m_acc = W'(s % full);
            return {s >= full, m_acc};
         end
      endcase
   endfunction

   // Output monitor, mid-cycle: count, in-order data (also covers hold stability), flag on transfer.
   always @(negedge clk) begin
      if (!rst) begin
         check("out_count", 32'(bus.out_count), 32'(m_count));
         if (bus.out_valid) begin
            if (sb_q.size() == 0) begin
               check("unexpected_out", 32'(bus.out_valid), 32'(0));
            end else begin
               check("out_data", 32'(bus.out_data), 32'(sb_q[0][W-1:0]));
               if (bus.out_ready) begin
                  check("out_flag", 32'(bus.out_flag), 32'(sb_q[0][W]));
                  void'(sb_q.pop_front());
                  m_count++;
               end
            end
         end
      end
   end

   // Offer one op; returns at posedge+1 after it is accepted (or after the budget expires).
   task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [1:0] mode, input bit clr);
      bit rdy = 1'b0;
      int i = 0;
      bus.in_valid = 1'b1;
      bus.in_a     = a;
      bus.in_b     = b;
      bus.in_mode  = mode;
      while (!rdy && i < 200) begin
         @(negedge clk);
         rdy = bus.in_ready;
         @(posedge clk);
         #1;
         bus.acc_clr = 1'b0;
         i++;
      end
      if (!rdy) begin
         check("accept_timeout", 32'(bus.in_ready), 32'(1));
      end else begin
         sb_q.push_back(model(a, b, mode, clr));
         // clear lands on the edge that moves this op into stage 2
         bus.acc_clr = clr;
      end
   endtask

   task automatic idle(input int n);
      bus.in_valid = 1'b0;
      repeat (n) begin
         @(posedge clk);
         #1;
         bus.acc_clr = 1'b0;
      end
   endtask

   task automatic drain();
      int i = 0;
      bus.in_valid = 1'b0;
      while (sb_q.size() != 0 && i < 200) begin
         @(posedge clk);
         #1;
         bus.acc_clr = 1'b0;
         i++;
      end
      check("drain", 32'(sb_q.size()), 32'(0));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst          = 1'b1;
      bus.in_valid = 1'b0;
      bus.in_a     = '0;
      bus.in_b     = '0;
      bus.in_mode  = M_ADD;
      bus.acc_clr  = 1'b0;
      bus.out_ready = 1'b1;
      tog_en       = 1'b0;

      // reset state
      repeat (2) @(posedge clk);
      #1;
      check("rst_out_valid", 32'(bus.out_valid), 32'(0));
      check("rst_in_ready",  32'(bus.in_ready),  32'(0));
      check("rst_out_data",  32'(bus.out_data),  32'(0));
      check("rst_out_flag",  32'(bus.out_flag),  32'(0));
      check("rst_out_count", 32'(bus.out_count), 32'(0));
      rst = 1'b0;
      #1;
      check("rel_in_ready", 32'(bus.in_ready), 32'(1));
      @(posedge clk);
      #1;

      // ADD with latency: s1 after accept edge, out_valid after the following edge
      send(8'd200, 8'd100, M_ADD, 1'b0);
      bus.in_valid = 1'b0;
      check("lat_edge1_valid", 32'(bus.out_valid), 32'(0));
      @(posedge clk);
      #1;
      check("lat_edge2_valid", 32'(bus.out_valid), 32'(1));
      check("add_data",        32'(bus.out_data),  32'(44));
      check("add_flag",        32'(bus.out_flag),  32'(1));
      @(posedge clk);
      #1;
      check("add_count",       32'(bus.out_count), 32'(1));
      drain();

      // SUB / SATADD, back-to-back
      send(8'd5,   8'd7,   M_SUB, 1'b0);
      send(8'd7,   8'd5,   M_SUB, 1'b0);
      send(8'd200, 8'd100, M_SAT, 1'b0);
      send(8'd100, 8'd50,  M_SAT, 1'b0);
      idle(1);
      drain();

      // accumulator stream, then clear coincident with ACC 7, then ACC 1
      send(8'd100, 8'd0, M_ACC, 1'b0);
      send(8'd150, 8'd0, M_ACC, 1'b0);
      send(8'd10,  8'd0, M_ACC, 1'b0);
      send(8'd7,   8'd0, M_ACC, 1'b1);
      send(8'd1,   8'd0, M_ACC, 1'b0);
      idle(1);
      drain();

      // backpressure: two ops fill the pipe, third must be refused
      cnt0 = m_count;
      bus.out_ready = 1'b0;
      send(8'd1, 8'd1, M_ADD, 1'b0);
      send(8'd2, 8'd2, M_ADD, 1'b0);
      bus.in_a = 8'd3;
      bus.in_b = 8'd3;
      @(negedge clk);
      check("bp_in_ready_a", 32'(bus.in_ready), 32'(0));
      @(posedge clk);
      #1;
      @(negedge clk);
      check("bp_in_ready_b", 32'(bus.in_ready), 32'(0));
      check("bp_hold_valid", 32'(bus.out_valid), 32'(1));
      @(posedge clk);
      #1;
      bus.out_ready = 1'b1;
      send(8'd3, 8'd3, M_ADD, 1'b0);
      send(8'd4, 8'd4, M_ADD, 1'b0);
      idle(1);
      drain();
      check("bp_count", 32'(bus.out_count), 32'(cnt0) + 32'(4));

      // random ops with out_ready toggling every cycle
      tog_en = 1'b1;
      fork
         begin
            for (int k = 0; k < 20; k++)
               send(W'($urandom_range(0, 255)), W'($urandom_range(0, 255)),
                    2'($urandom_range(0, 3)), 1'b0);
            bus.in_valid = 1'b0;
            tog_en = 1'b0;
         end
         begin
            while (tog_en) begin
               @(posedge clk);
               #1;
               bus.out_ready = ~bus.out_ready;
            end
         end
      join
      bus.out_ready = 1'b1;
      drain();

      // reset with two ops in flight
      bus.out_ready = 1'b0;
      send(8'd9, 8'd9, M_ADD, 1'b0);
      send(8'd3, 8'd4, M_ACC, 1'b0);
      bus.in_valid = 1'b0;
      rst = 1'b1;
      #1;
      check("mid_rst_out_valid", 32'(bus.out_valid), 32'(0));
      check("mid_rst_in_ready",  32'(bus.in_ready),  32'(0));
      sb_q.delete();
      m_count = '0;
      m_acc   = '0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      bus.out_ready = 1'b1;
      idle(4);
      check("post_rst_count", 32'(bus.out_count), 32'(0));
      send(8'd5, 8'd0, M_ACC, 1'b0);
      idle(1);
      drain();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
